// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if: bundles the W-stage, MDU and register-file write-port
// signals of wb_port_arbiter. Optional overflow-trap signals exist only when
// WB_OVF_TRAP_EN is defined.
interface wb_port_arbiter_if;
  logic        W_RegWr;
  logic        W_MemtoReg;
  logic [31:0] W_Dout;
  logic [31:0] W_ALUout;
  logic        W_Overflow;
  logic [4:0]  W_Rw;
  logic        Md_Valid;
  logic [4:0]  Md_Rw;
  logic [31:0] Md_Data;
  logic        Md_Ready;
  logic        Stall;
  logic        Rf_We;
  logic [4:0]  Rf_Rw;
  logic [31:0] Rf_Din;
`ifdef WB_OVF_TRAP_EN
  logic        Ovf_Trap;
  logic [4:0]  Ovf_Rw;
`endif

  modport master (
    output W_RegWr, W_MemtoReg, W_Dout, W_ALUout, W_Overflow, W_Rw,
    output Md_Valid, Md_Rw, Md_Data,
    input  Md_Ready, Stall, Rf_We, Rf_Rw, Rf_Din
`ifdef WB_OVF_TRAP_EN
    , input Ovf_Trap, Ovf_Rw
`endif
  );

  modport slave (
    input  W_RegWr, W_MemtoReg, W_Dout, W_ALUout, W_Overflow, W_Rw,
    input  Md_Valid, Md_Rw, Md_Data,
    output Md_Ready, Stall, Rf_We, Rf_Rw, Rf_Din
`ifdef WB_OVF_TRAP_EN
    , output Ovf_Trap, Ovf_Rw
`endif
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the W stage
// and buffered MDU results. The W stage has priority; MDU results drain in
// idle slots, and a starvation counter forces a one-cycle stall so the FIFO
// head gets written. Optional feature macro: WB_OVF_TRAP_EN (suppress
// overflowing W writes and report them on Ovf_Trap/Ovf_Rw).
module wb_port_arbiter #(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned MAX_WAIT = 4
) (
  input logic              Clk,
  input logic              Reset,
  wb_port_arbiter_if.slave bus
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned WW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [WW-1:0] WAIT_LIM = WW'(MAX_WAIT);

  logic [4:0]       fifo_rw   [DEPTH];
  logic [31:0]      fifo_data [DEPTH];
  logic [DEPTH-1:0] fifo_kill;
  logic [AW-1:0]    head_q, tail_q;
  logic [CW-1:0]    count_q, count_next;
  logic [WW-1:0]    wait_q, wait_next;
  logic             stall_q, stall_next;
  logic             rf_we_q;
  logic [4:0]       rf_rw_q;
  logic [31:0]      rf_din_q;

  logic             md_ready, w_write, wreq, push, pop, drain, head_kill, pending;
  logic [AW-1:0]    offs [DEPTH];
  logic [DEPTH-1:0] entry_valid, kill_hit;

`ifdef WB_OVF_TRAP_EN
  logic             ovf_hit;
  logic             ovf_trap_q;
  logic [4:0]       ovf_rw_q;
`else
  logic             unused_ovf;
  assign unused_ovf = bus.W_Overflow;
`endif

  // Request qualification, grant decision, kill matching and starvation tracking
  always_comb begin
    md_ready = (count_q < FULL_CNT);
    w_write  = bus.W_RegWr && (bus.W_Rw != 5'd0) && !stall_q;
`ifdef WB_OVF_TRAP_EN
    ovf_hit  = w_write && bus.W_Overflow;
    wreq     = w_write && !bus.W_Overflow;
`else
    wreq     = w_write;
`endif
    head_kill = (count_q != '0) && fifo_kill[head_q];
    drain     = !wreq && (count_q != '0) && !fifo_kill[head_q];
    pop       = head_kill || drain;
    push      = bus.Md_Valid && md_ready && (bus.Md_Rw != 5'd0);

    // Entries that stay live after this cycle's kills keep the wait counter running
    pending = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offs[i]        = AW'(i) - head_q;
      entry_valid[i] = (CW'(offs[i]) < count_q);
      kill_hit[i]    = wreq && entry_valid[i] && (fifo_rw[i] == bus.W_Rw);
      if (entry_valid[i] && !fifo_kill[i] && !kill_hit[i]) pending = 1'b1;
    end

    count_next = count_q + CW'(push) - CW'(pop);

    if (stall_q)                wait_next = '0;
    else if (wreq && pending)   wait_next = wait_q + WW'(1);
    else if (count_next == '0)  wait_next = '0;
    else                        wait_next = wait_q;

    stall_next = !stall_q && (wait_next == WAIT_LIM);
  end

  // FIFO storage: kill marking on W grants, tail write on accepted MDU results
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_rw[i]   <= '0;
        fifo_data[i] <= '0;
      end
      fifo_kill <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (kill_hit[i]) fifo_kill[i] <= 1'b1;
      end
      // The tail slot is never live when push is allowed, so the fresh entry is never killed
      if (push) begin
        fifo_rw[tail_q]   <= bus.Md_Rw;
        fifo_data[tail_q] <= bus.Md_Data;
        fifo_kill[tail_q] <= 1'b0;
      end
    end
  end

  // Pointers, occupancy, starvation counter and forced-drain stall
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      wait_q  <= '0;
      stall_q <= 1'b0;
    end else begin
      head_q  <= head_q + AW'(pop);
      tail_q  <= tail_q + AW'(push);
      count_q <= count_next;
      wait_q  <= wait_next;
      stall_q <= stall_next;
    end
  end

  // Registered register-file write port; address/data hold when idle
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rf_we_q  <= 1'b0;
      rf_rw_q  <= '0;
      rf_din_q <= '0;
    end else if (wreq) begin
      rf_we_q  <= 1'b1;
      rf_rw_q  <= bus.W_Rw;
      rf_din_q <= bus.W_MemtoReg ? bus.W_Dout : bus.W_ALUout;
    end else if (drain) begin
      rf_we_q  <= 1'b1;
      rf_rw_q  <= fifo_rw[head_q];
      rf_din_q <= fifo_data[head_q];
    end else begin
      rf_we_q  <= 1'b0;
    end
  end

`ifdef WB_OVF_TRAP_EN
  // One-cycle trap pulse and captured destination for suppressed overflow writes
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ovf_trap_q <= 1'b0;
      ovf_rw_q   <= '0;
    end else begin
      ovf_trap_q <= ovf_hit;
      if (ovf_hit) ovf_rw_q <= bus.W_Rw;
    end
  end

  assign bus.Ovf_Trap = ovf_trap_q;
  assign bus.Ovf_Rw   = ovf_rw_q;
`endif

  assign bus.Md_Ready = md_ready;
  assign bus.Stall    = stall_q;
  assign bus.Rf_We    = rf_we_q;
  assign bus.Rf_Rw    = rf_rw_q;
  assign bus.Rf_Din   = rf_din_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed scenarios plus randomized traffic for
// wb_port_arbiter, checked against a queue-based reference model.
module tb_wb_port_arbiter;
  localparam int unsigned DEPTH    = 2;
  localparam int unsigned MAX_WAIT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_port_arbiter_if bus();

  wb_port_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .Clk  (clk),
    .Reset(rst),
    .bus  (bus)
  );

  typedef struct {
    logic [4:0]  rw;
    logic [31:0] data;
    bit          killed;
  } ent_t;

  ent_t        q[$];
  int unsigned m_wait;
  bit          m_stall, m_we, last_stall, md_blocked;
  logic [4:0]  m_rw;
  logic [31:0] m_din;
  bit          m_trap;
  logic [4:0]  m_ovf_rw;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_wait = 0; m_stall = 0; m_we = 0; m_rw = '0; m_din = '0;
    m_trap = 0; m_ovf_rw = '0; last_stall = 0; md_blocked = 0;
  endtask

  // Advance the reference by one clock using the inputs currently applied
  task automatic model_step();
    bit ready, wv, ovf, hk, pend;
    ready = (q.size() < DEPTH);
    wv    = bus.W_RegWr && (bus.W_Rw != 5'd0) && !m_stall;
    ovf   = 0;
`ifdef WB_OVF_TRAP_EN
    ovf = wv && bus.W_Overflow;
    wv  = wv && !bus.W_Overflow;
`endif
    hk   = (q.size() > 0) && q[0].killed;
    pend = 0;
    foreach (q[i]) if (!q[i].killed && !(wv && q[i].rw == bus.W_Rw)) pend = 1;
    last_stall = m_stall;
    md_blocked = bus.Md_Valid && !ready;

    if (wv) begin
      m_we = 1; m_rw = bus.W_Rw; m_din = bus.W_MemtoReg ? bus.W_Dout : bus.W_ALUout;
    end else if (q.size() > 0 && !hk) begin
      m_we = 1; m_rw = q[0].rw; m_din = q[0].data;
      void'(q.pop_front());
    end else begin
      m_we = 0;
    end
    if (hk) void'(q.pop_front());
    if (wv) foreach (q[i]) if (q[i].rw == bus.W_Rw) q[i].killed = 1;
    if (bus.Md_Valid && ready && bus.Md_Rw != 5'd0)
      q.push_back('{rw: bus.Md_Rw, data: bus.Md_Data, killed: 0});

    if (m_stall)          m_wait = 0;
    else if (wv && pend)  m_wait = m_wait + 1;
    else if (q.size() == 0) m_wait = 0;
    m_stall = !m_stall && (m_wait == MAX_WAIT);

    m_trap = ovf;
    if (ovf) m_ovf_rw = bus.W_Rw;
  endtask

  task automatic compare_all();
    check("md_ready", 32'(bus.Md_Ready), 32'(q.size() < DEPTH));
    check("stall",    32'(bus.Stall),    32'(m_stall));
    check("rf_we",    32'(bus.Rf_We),    32'(m_we));
    check("rf_rw",    32'(bus.Rf_Rw),    32'(m_rw));
    check("rf_din",   bus.Rf_Din,        m_din);
`ifdef WB_OVF_TRAP_EN
    check("ovf_trap", 32'(bus.Ovf_Trap), 32'(m_trap));
    check("ovf_rw",   32'(bus.Ovf_Rw),   32'(m_ovf_rw));
`endif
  endtask

  task automatic set_in(input bit regwr, input bit m2r, input logic [31:0] dout,
                        input logic [31:0] alu, input bit ovf, input logic [4:0] rw,
                        input bit mdv, input logic [4:0] mdrw, input logic [31:0] mdd);
    bus.W_RegWr = regwr; bus.W_MemtoReg = m2r; bus.W_Dout = dout; bus.W_ALUout = alu;
    bus.W_Overflow = ovf; bus.W_Rw = rw;
    bus.Md_Valid = mdv; bus.Md_Rw = mdrw; bus.Md_Data = mdd;
  endtask

  task automatic idle();
    set_in(0, 0, '0, '0, 0, '0, 0, '0, '0);
  endtask

  task automatic step();
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    model_reset();
    @(negedge clk);
    compare_all();
    rst = 1'b0;
  endtask

  // Random W/MDU traffic honouring stall re-presentation and MDU hold
  task automatic drive_random();
    if (!last_stall) begin
      bus.W_RegWr    = ($urandom_range(0, 9) < 6);
      bus.W_MemtoReg = 1'($urandom_range(0, 1));
      bus.W_Dout     = $urandom;
      bus.W_ALUout   = $urandom;
      bus.W_Overflow = ($urandom_range(0, 7) == 0);
      bus.W_Rw       = 5'($urandom_range(0, 7));
    end
    if (!md_blocked) begin
      bus.Md_Valid = ($urandom_range(0, 9) < 4);
      bus.Md_Rw    = 5'($urandom_range(0, 7));
      bus.Md_Data  = $urandom;
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    @(negedge clk);
    do_reset();

    // W-stage write only, then a write to r0
    set_in(1, 1, 32'h1234, 32'h5555, 0, 5'd5, 0, '0, '0); step();
    check("w_we", 32'(bus.Rf_We), 32'd1);
    check("w_rw", 32'(bus.Rf_Rw), 32'd5);
    check("w_din", bus.Rf_Din, 32'h1234);
    set_in(1, 0, 32'h1, 32'h2, 0, 5'd0, 0, '0, '0); step();
    check("w_r0_we", 32'(bus.Rf_We), 32'd0);

    // MDU result drains in an idle slot
    set_in(0, 0, '0, '0, 0, '0, 1, 5'd8, 32'hDEADBEEF); step();
    idle(); step();
    check("drain_we", 32'(bus.Rf_We), 32'd1);
    check("drain_rw", 32'(bus.Rf_Rw), 32'd8);
    check("drain_din", bus.Rf_Din, 32'hDEADBEEF);

    // Full FIFO and forced drain after MAX_WAIT W grants
    do_reset();
    set_in(1, 0, '0, 32'h33, 0, 5'd3, 1, 5'd9, 32'h9999); step();
    set_in(1, 0, '0, 32'h33, 0, 5'd3, 1, 5'd10, 32'hAAAA); step();
    check("full_ready", 32'(bus.Md_Ready), 32'd0);
    set_in(1, 0, '0, 32'h33, 0, 5'd3, 0, '0, '0);
    step(); step(); step();
    check("starve_stall", 32'(bus.Stall), 32'd1);
    step();
    check("forced_rw", 32'(bus.Rf_Rw), 32'd9);
    check("forced_stall_clr", 32'(bus.Stall), 32'd0);
    step();
    check("represent_we", 32'(bus.Rf_We), 32'd1);
    check("represent_rw", 32'(bus.Rf_Rw), 32'd3);

    // Kill of an older entry; same-cycle push of the same Rw survives
    do_reset();
    set_in(0, 0, '0, '0, 0, '0, 1, 5'd7, 32'hA0A0A0A0); step();
    set_in(1, 0, '0, 32'h7777, 0, 5'd7, 1, 5'd7, 32'hB0B0B0B0); step();
    check("kill_w_rw", 32'(bus.Rf_Rw), 32'd7);
    check("kill_w_din", bus.Rf_Din, 32'h7777);
    idle(); step();
    check("kill_pop_we", 32'(bus.Rf_We), 32'd0);
    step();
    check("kill_keep_we", 32'(bus.Rf_We), 32'd1);
    check("kill_keep_din", bus.Rf_Din, 32'hB0B0B0B0);

    // Asynchronous reset in the middle of operation
    do_reset();
    set_in(1, 0, '0, 32'h1, 0, 5'd1, 1, 5'd20, 32'h20); step();
    set_in(1, 0, '0, 32'h2, 0, 5'd2, 1, 5'd21, 32'h21); step();
    idle();
    #2 rst = 1'b1;
    #1;
    check("rst_we", 32'(bus.Rf_We), 32'd0);
    check("rst_stall", 32'(bus.Stall), 32'd0);
    check("rst_ready", 32'(bus.Md_Ready), 32'd1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    compare_all();
    repeat (4) step();

`ifdef WB_OVF_TRAP_EN
    // Overflowing W write is suppressed; pending head drains in its slot
    do_reset();
    set_in(1, 0, '0, 32'h3, 0, 5'd3, 1, 5'd9, 32'h9009); step();
    set_in(1, 0, '0, 32'hC, 1, 5'd12, 0, '0, '0); step();
    check("ovf_trap_hi", 32'(bus.Ovf_Trap), 32'd1);
    check("ovf_rw_cap", 32'(bus.Ovf_Rw), 32'd12);
    check("ovf_drain_rw", 32'(bus.Rf_Rw), 32'd9);
    idle(); step();
    check("ovf_trap_lo", 32'(bus.Ovf_Trap), 32'd0);
`endif

    // Randomized traffic
    do_reset();
    repeat (800) begin
      drive_random();
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
